// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer write path.
// 320x200 words of 24-bit RGB.
package fb_pkg;

   localparam int FB_WORDS = 64000;
   localparam int ADR_W    = 16;
   localparam int DAT_W    = 24;

   typedef enum logic {
      ARB,
      CLEAR
   } state_t;

   typedef enum logic {
      REQ_CPU,
      REQ_TXT
   } req_id_t;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin grant between CPU and text renderer.
// Grants are combinational; last_grant moves only on a transfer.
module fb_rr_arb2
   import fb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic cpu_valid,
   input  logic txt_valid,
   output logic gnt_cpu,
   output logic gnt_txt
);

   req_id_t last_grant;

   always_comb begin
      gnt_cpu = en && cpu_valid &&
                (!txt_valid || last_grant == REQ_TXT);
      gnt_txt = en && txt_valid &&
                (!cpu_valid || last_grant == REQ_CPU);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= REQ_TXT;
      end else if (gnt_cpu) begin
         last_grant <= REQ_CPU;
      end else if (gnt_txt) begin
         last_grant <= REQ_TXT;
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: CPU and text renderer share one write port.
// Optional clear-screen engine is built when FB_CLEAR_EN is defined.
module fb_write_arbiter #(
   parameter int FB_WORDS = fb_pkg::FB_WORDS,
   parameter int ADR_W    = fb_pkg::ADR_W,
   parameter int DAT_W    = fb_pkg::DAT_W
) (
   input  logic             CLOCK_50,
   input  logic             rst,
   input  logic             cpu_valid,
   output logic             cpu_ready,
   input  logic [ADR_W-1:0] cpu_adr,
   input  logic [DAT_W-1:0] cpu_d,
   input  logic             txt_valid,
   output logic             txt_ready,
   input  logic [ADR_W-1:0] txt_adr,
   input  logic [DAT_W-1:0] txt_d,
   input  logic             clr_start,
   input  logic [DAT_W-1:0] clr_color,
   output logic             clr_busy,
   output logic             clr_done,
   output logic             fb_we,
   output logic [ADR_W-1:0] fb_wadr,
   output logic [DAT_W-1:0] fb_d,
   output logic             adr_err
);
   import fb_pkg::*;

   localparam logic [ADR_W:0] ADR_LIM = (ADR_W+1)'(FB_WORDS);

   logic             arb_en;
   logic             gnt_cpu;
   logic             gnt_txt;
   logic             xfer;
   logic             req_ok;
   logic [ADR_W-1:0] req_adr;
   logic [DAT_W-1:0] req_d;
   logic             we_nx;
   logic [ADR_W-1:0] adr_nx;
   logic [DAT_W-1:0] d_nx;

   fb_rr_arb2 u_arb (
      .clk       (CLOCK_50),
      .rst       (rst),
      .en        (arb_en),
      .cpu_valid (cpu_valid),
      .txt_valid (txt_valid),
      .gnt_cpu   (gnt_cpu),
      .gnt_txt   (gnt_txt)
   );

   assign cpu_ready = gnt_cpu;
   assign txt_ready = gnt_txt;
   assign xfer      = gnt_cpu || gnt_txt;
   assign req_adr   = gnt_cpu ? cpu_adr : txt_adr;
   assign req_d     = gnt_cpu ? cpu_d : txt_d;
   assign req_ok    = {1'b0, req_adr} < ADR_LIM;

`ifdef FB_CLEAR_EN

   localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(FB_WORDS - 1);

   state_t           state;
   state_t           state_nx;
   logic [ADR_W-1:0] clr_cnt;
   logic [ADR_W-1:0] cnt_nx;
   logic [DAT_W-1:0] clr_col;

   // clr_start steals the cycle so no requester transfers alongside it
   assign arb_en   = state == ARB && !clr_start && !rst;
   assign clr_busy = state == CLEAR;
   assign clr_done = state == CLEAR && clr_cnt == ADR_LAST;

   always_comb begin
      state_nx = state;
      cnt_nx   = clr_cnt;
      we_nx    = 1'b0;
      adr_nx   = fb_wadr;
      d_nx     = fb_d;
      unique case (state)
         ARB: begin
            if (clr_start) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
               we_nx    = 1'b1;
               adr_nx   = '0;
               d_nx     = clr_color;
            end else if (xfer && req_ok) begin
               we_nx  = 1'b1;
               adr_nx = req_adr;
               d_nx   = req_d;
            end
         end
         CLEAR: begin
            if (clr_cnt == ADR_LAST) begin
               state_nx = ARB;
            end else begin
               cnt_nx = clr_cnt + 1'b1;
               we_nx  = 1'b1;
               adr_nx = clr_cnt + 1'b1;
               d_nx   = clr_col;
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         state   <= ARB;
         clr_cnt <= '0;
         clr_col <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= cnt_nx;
         if (state == ARB && clr_start) begin
            clr_col <= clr_color;
         end
      end
   end

`else

   logic unused_clr;

   assign unused_clr = ^{clr_start, clr_color};
   assign arb_en     = !rst;
   assign clr_busy   = 1'b0;
   assign clr_done   = 1'b0;

   always_comb begin
      we_nx  = 1'b0;
      adr_nx = fb_wadr;
      d_nx   = fb_d;
      if (xfer && req_ok) begin
         we_nx  = 1'b1;
         adr_nx = req_adr;
         d_nx   = req_d;
      end
   end

`endif

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         fb_we   <= 1'b0;
         fb_wadr <= '0;
         fb_d    <= '0;
         adr_err <= 1'b0;
      end else begin
         fb_we   <= we_nx;
         fb_wadr <= adr_nx;
         fb_d    <= d_nx;
         if (xfer && !req_ok) begin
            adr_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a 16-word framebuffer.
// Clear-engine sequences are built when FB_CLEAR_EN is defined.
module tb_fb_write_arbiter;

   localparam int FBW = 16;

   logic        clk;
   logic        rst;
   logic        cpu_valid;
   logic        cpu_ready;
   logic [15:0] cpu_adr;
   logic [23:0] cpu_d;
   logic        txt_valid;
   logic        txt_ready;
   logic [15:0] txt_adr;
   logic [23:0] txt_d;
   logic        clr_start;
   logic [23:0] clr_color;
   logic        clr_busy;
   logic        clr_done;
   logic        fb_we;
   logic [15:0] fb_wadr;
   logic [23:0] fb_d;
   logic        adr_err;

   int n_cmp;
   int n_bad;

   fb_write_arbiter #(
      .FB_WORDS (FBW),
      .ADR_W    (16),
      .DAT_W    (24)
   ) dut (
      .CLOCK_50  (clk),
      .rst       (rst),
      .cpu_valid (cpu_valid),
      .cpu_ready (cpu_ready),
      .cpu_adr   (cpu_adr),
      .cpu_d     (cpu_d),
      .txt_valid (txt_valid),
      .txt_ready (txt_ready),
      .txt_adr   (txt_adr),
      .txt_d     (txt_d),
      .clr_start (clr_start),
      .clr_color (clr_color),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .fb_we     (fb_we),
      .fb_wadr   (fb_wadr),
      .fb_d      (fb_d),
      .adr_err   (adr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cv;
      logic [15:0] ca;
      logic [23:0] cd;
      logic        tv;
      logic [15:0] ta;
      logic [23:0] td;
      logic        ecr;
      logic        etr;
      logic        ewe;
      logic [15:0] eadr;
      logic [23:0] ed;
      logic        eerr;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic cv, input logic [15:0] ca, input logic [23:0] cd,
      input logic tv, input logic [15:0] ta, input logic [23:0] td,
      input logic ecr, input logic etr, input logic ewe,
      input logic [15:0] eadr, input logic [23:0] ed, input logic eerr);
      vec_t v;
      v.cv = cv; v.ca = ca; v.cd = cd;
      v.tv = tv; v.ta = ta; v.td = td;
      v.ecr = ecr; v.etr = etr; v.ewe = ewe;
      v.eadr = eadr; v.ed = ed; v.eerr = eerr;
      return v;
   endfunction

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      cpu_valid = 1'b1;
      cpu_adr   = 16'd1;
      cpu_d     = 24'h0;
      txt_valid = 1'b1;
      txt_adr   = 16'd2;
      txt_d     = 24'h0;
      clr_start = 1'b0;
      clr_color = 24'h0;

      // both tied with last_grant=txt: CPU, TXT, CPU, TXT
      vt[0]  = mk(0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0);
      vt[1]  = mk(1, 1, 24'hAAAAAA, 1, 2, 24'hBBBBBB,
                  1, 0, 1, 1, 24'hAAAAAA, 0);
      vt[2]  = mk(1, 3, 24'hCCCCCC, 1, 2, 24'hBBBBBB,
                  0, 1, 1, 2, 24'hBBBBBB, 0);
      vt[3]  = mk(1, 3, 24'hCCCCCC, 1, 4, 24'hDDDDDD,
                  1, 0, 1, 3, 24'hCCCCCC, 0);
      vt[4]  = mk(1, 5, 24'hEEEEEE, 1, 4, 24'hDDDDDD,
                  0, 1, 1, 4, 24'hDDDDDD, 0);
      vt[5]  = mk(0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0);
      vt[6]  = mk(1, 10, 24'hFF0000, 0, 0, 0,
                  1, 0, 1, 10, 24'hFF0000, 0);
      vt[7]  = mk(1, 11, 24'hFF0000, 0, 0, 0,
                  1, 0, 1, 11, 24'hFF0000, 0);
      vt[8]  = mk(1, 12, 24'hFF0000, 0, 0, 0,
                  1, 0, 1, 12, 24'hFF0000, 0);
      vt[9]  = mk(0, 0, 0, 1, 15, 24'h0000FF,
                  0, 1, 1, 15, 24'h0000FF, 0);
      vt[10] = mk(1, 16, 24'h123456, 0, 0, 0,
                  1, 0, 0, 0, 0, 1);
      vt[11] = mk(1, 16'd64000, 24'h654321, 0, 0, 0,
                  1, 0, 0, 0, 0, 1);
      vt[12] = mk(0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 1);
      vt[13] = mk(1, 7, 24'h777777, 1, 8, 24'h888888,
                  0, 1, 1, 8, 24'h888888, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_txt_ready", txt_ready, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_wadr", fb_wadr, 0);
      chk("rst_fb_d", fb_d, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_adr_err", adr_err, 0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (i != 0) @(negedge clk);
         cpu_valid = vt[i].cv;
         cpu_adr   = vt[i].ca;
         cpu_d     = vt[i].cd;
         txt_valid = vt[i].tv;
         txt_adr   = vt[i].ta;
         txt_d     = vt[i].td;
         #1;
         chk($sformatf("v%0d_cpu_ready", i), cpu_ready, vt[i].ecr);
         chk($sformatf("v%0d_txt_ready", i), txt_ready, vt[i].etr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_fb_we", i), fb_we, vt[i].ewe);
         if (vt[i].ewe) begin
            chk($sformatf("v%0d_fb_wadr", i), fb_wadr, vt[i].eadr);
            chk($sformatf("v%0d_fb_d", i), fb_d, vt[i].ed);
         end
         chk($sformatf("v%0d_adr_err", i), adr_err, vt[i].eerr);
      end

      @(negedge clk);
      cpu_valid = 1'b0;
      txt_valid = 1'b0;

`ifdef FB_CLEAR_EN
      // clear with txt held; a second clr_start mid-clear must be ignored
      @(negedge clk);
      txt_valid = 1'b1;
      txt_adr   = 16'd3;
      txt_d     = 24'h123456;
      clr_start = 1'b1;
      clr_color = 24'h00FF00;
      #1;
      chk("clr_start_txt_ready", txt_ready, 0);
      @(posedge clk);
      #1;
      clr_start = 1'b0;
      for (int k = 0; k < FBW; k++) begin
         chk($sformatf("clr%0d_busy", k), clr_busy, 1);
         chk($sformatf("clr%0d_we", k), fb_we, 1);
         chk($sformatf("clr%0d_wadr", k), fb_wadr, k);
         chk($sformatf("clr%0d_d", k), fb_d, 24'h00FF00);
         chk($sformatf("clr%0d_done", k), clr_done, k == FBW - 1);
         chk($sformatf("clr%0d_txt_ready", k), txt_ready, 0);
         if (k == 5) begin
            clr_start = 1'b1;
            clr_color = 24'hABCDEF;
         end else begin
            clr_start = 1'b0;
         end
         if (k < FBW - 1) begin
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      chk("clr_end_busy", clr_busy, 0);
      chk("clr_end_done", clr_done, 0);
      chk("clr_end_we", fb_we, 0);
      chk("clr_end_txt_ready", txt_ready, 1);
      @(posedge clk);
      #1;
      txt_valid = 1'b0;
      chk("post_clr_txt_we", fb_we, 1);
      chk("post_clr_txt_adr", fb_wadr, 3);
      chk("post_clr_txt_d", fb_d, 24'h123456);
      @(posedge clk);
      #1;
      chk("post_clr_no_dup", fb_we, 0);

      // reset at clear address 7 aborts the clear
      @(negedge clk);
      clr_start = 1'b1;
      clr_color = 24'h0F0F0F;
      @(posedge clk);
      #1;
      clr_start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("abort_at_adr", fb_wadr, 7);
      rst = 1'b1;
      #1;
      chk("abort_we", fb_we, 0);
      chk("abort_wadr", fb_wadr, 0);
      chk("abort_d", fb_d, 0);
      chk("abort_busy", clr_busy, 0);
      chk("abort_done", clr_done, 0);
      chk("abort_adr_err", adr_err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      cpu_valid = 1'b1;
      cpu_adr   = 16'd9;
      cpu_d     = 24'h999999;
      txt_valid = 1'b1;
      txt_adr   = 16'd6;
      txt_d     = 24'h666666;
      #1;
      chk("abort_arb_busy", clr_busy, 0);
      chk("abort_cpu_ready", cpu_ready, 1);
      chk("abort_txt_ready", txt_ready, 0);
      @(posedge clk);
      #1;
      cpu_valid = 1'b0;
      chk("abort_wr_adr", fb_wadr, 9);
      chk("abort_wr_we", fb_we, 1);
      @(posedge clk);
      #1;
      txt_valid = 1'b0;
      chk("abort_txt_adr", fb_wadr, 6);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk);
         #1;
         chk($sformatf("no_resume%0d_we", j), fb_we, 0);
         chk($sformatf("no_resume%0d_busy", j), clr_busy, 0);
         chk($sformatf("no_resume%0d_done", j), clr_done, 0);
      end
`else
      // clr_start is inert: CPU traffic flows straight through it
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_adr   = 16'd5;
      cpu_d     = 24'h505050;
      clr_start = 1'b1;
      clr_color = 24'h00FF00;
      #1;
      chk("noclr_cpu_ready", cpu_ready, 1);
      chk("noclr_busy", clr_busy, 0);
      @(posedge clk);
      #1;
      clr_start = 1'b0;
      cpu_adr   = 16'd6;
      chk("noclr_we0", fb_we, 1);
      chk("noclr_adr0", fb_wadr, 5);
      chk("noclr_d0", fb_d, 24'h505050);
      chk("noclr_busy1", clr_busy, 0);
      chk("noclr_done1", clr_done, 0);
      @(posedge clk);
      #1;
      cpu_valid = 1'b0;
      chk("noclr_we1", fb_we, 1);
      chk("noclr_adr1", fb_wadr, 6);
      @(posedge clk);
      #1;
      chk("noclr_idle_we", fb_we, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_WORDS, default 64000: number of valid framebuffer word addresses (320x200).
REQ-002 SHALL have parameter ADR_W, default 16: framebuffer address width.
REQ-003 SHALL have parameter DAT_W, default 24: pixel width (8-bit R,G,B).
REQ-004 SHALL have port CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cpu_valid/cpu_ready  input/output  1/1  CPU write handshake.
REQ-007 SHALL have ports cpu_adr, cpu_d  input  ADR_W, DAT_W  CPU write address and pixel.
REQ-008 SHALL have ports txt_valid/txt_ready  input/output  1/1  text-renderer write handshake.
REQ-009 SHALL have ports txt_adr, txt_d  input  ADR_W, DAT_W  text-renderer write address and pixel.
REQ-010 SHALL have ports clr_start, clr_color  input  1, DAT_W  clear-screen request pulse and fill colour.
REQ-011 SHALL have ports clr_busy, clr_done  output  1, 1  clear in progress; one-cycle completion pulse.
REQ-012 SHALL have ports fb_we, fb_wadr, fb_d  output  1, ADR_W, DAT_W  registered framebuffer write port.
REQ-013 SHALL have port adr_err  output  1  sticky flag: an out-of-range write was dropped.

Function
REQ-014 SHALL implement states ARB and CLEAR; reset enters ARB.
REQ-015 A transfer SHALL occur on a requester in any cycle where its valid and ready are both 1.
REQ-016 In ARB, ready SHALL be combinational: at most one of cpu_ready/txt_ready high, only toward a requester with valid=1.
REQ-017 Arbitration SHALL be round-robin: when both valid, grant goes to the requester not granted last; last_grant updates only on transfer; last_grant resets to txt (CPU wins first tie).
REQ-018 A transfer SHALL appear on fb_we/fb_wadr/fb_d exactly one cycle later (latency 1); fb_we otherwise 0.
REQ-019 Sustained throughput SHALL be one write per cycle with no bubbles between grants.
REQ-020 A transfer with adr >= FB_WORDS SHALL be acknowledged, produce fb_we=0, and set adr_err until reset.
REQ-021 clr_start in ARB SHALL force both ready to 0 that cycle and enter CLEAR next cycle; no requester transfer in that cycle.
REQ-022 In CLEAR: clr_busy=1, both ready=0, fb_we=1 every cycle, fb_wadr counting 0..FB_WORDS-1, fb_d = clr_color latched at clr_start.
REQ-023 After the write of address FB_WORDS-1, SHALL pulse clr_done one cycle (coincident with that write) and return to ARB the next cycle.
REQ-024 clr_start during CLEAR SHALL be ignored (no restart).
REQ-025 Requesters whose valid is held through CLEAR SHALL be served normally once ARB resumes; address/data unchanged (no loss, no duplication).

Reset
REQ-026 Reset SHALL drive fb_we=0, fb_wadr=0, fb_d=0, cpu_ready=0, txt_ready=0 (while asserted), clr_busy=0, clr_done=0, adr_err=0, clear counter=0, last_grant=txt.
REQ-027 Reset during CLEAR SHALL abort it with no clr_done pulse; the partial clear is not resumed.

Configuration
REQ-028 Macro FB_CLEAR_EN SHALL gate the clear engine.
REQ-029 With FB_CLEAR_EN defined, REQ-021..REQ-025 apply.
REQ-030 Without FB_CLEAR_EN: no CLEAR state or counter; clr_start and clr_color ignored; clr_busy and clr_done tied 0; ports retained.

Structure
REQ-031 Package fb_pkg SHALL hold FB_WORDS default, ADR_W, DAT_W, the state enum (ARB, CLEAR) and the requester-id enum (REQ_CPU, REQ_TXT).
REQ-032 Sub-module fb_rr_arb2 SHALL hold the two-way round-robin grant logic and last_grant register; the rest stays in fb_write_arbiter.

Verification
REQ-033 CPU only, cpu_valid held 3 cycles adr 10,11,12 d 0xFF0000 -> fb_we high 3 consecutive cycles, one cycle delayed, adr 10,11,12.
REQ-034 Both valid continuously after reset -> grants alternate CPU,TXT,CPU,TXT; fb_we never drops.
REQ-035 cpu_adr=64000 transfer -> cpu_ready=1, no fb_we, adr_err=1 and stays set.
REQ-036 FB_WORDS=16, clr_start with clr_color 0x00FF00 while txt_valid held -> 16 writes adr 0..15 of 0x00FF00, clr_done with adr 15, txt served on the following ARB cycle.
REQ-037 rst asserted at clear address 7 -> all outputs reset immediately, no clr_done, ARB after release.
REQ-038 Build without FB_CLEAR_EN, pulse clr_start -> clr_busy=0, requester traffic uninterrupted.
